// File: rtl/up_dn_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : up_dn_cmd_gen
//  Description : Turns three raw push buttons (up, down, load) into clean
//                single-cycle Load/Up/Down command pulses for a 5-bit
//                up/down counter. It synchronizes and debounces each button,
//                auto-repeats a held Up/Down button, and suppresses Up at the
//                counter's maximum and Down at its minimum.
//  Revision    : 1.0 - initial release
// ============================================================================
module up_dn_cmd_gen #(
    parameter int DB_CYCLES = 4,
    parameter int RPT_DELAY = 16,
    parameter int RPT_RATE  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Btn_Up,
    input  logic       Btn_Dn,
    input  logic       Btn_Ld,
    input  logic [4:0] IN_Sw,
    input  logic       High,
    input  logic       Low,
    output logic [4:0] IN,
    output logic       Load,
    output logic       Up,
    output logic       Down
);

    // Button slots in the internal 3-bit vectors
    localparam int c_BTN_UP = 0;
    localparam int c_BTN_DN = 1;
    localparam int c_BTN_LD = 2;

    // The debounce counter only ever has to reach DB_CYCLES-1
    localparam int c_CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DB_CYCLES - 1);

    // Repeat timer sized so the larger interval fits without wrapping
    localparam int c_TMR_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam logic [c_TMR_W-1:0] c_DLY_LAST = c_TMR_W'(RPT_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_RATE_LAST = c_TMR_W'(RPT_RATE - 1);

    // Command FSM encoding
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_HOLD_DLY = 2'd1;
    localparam logic [1:0] c_REPEAT   = 2'd2;

    logic [2:0] w_raw;
    logic [2:0] w_deb;
    logic [2:0] w_press;
    logic       w_held_lvl;

    logic [1:0]         r_state;
    logic               r_dir_dn;
    logic [c_TMR_W-1:0] r_timer;
    logic [4:0]         r_in;
    logic               r_load;
    logic               r_up;
    logic               r_down;

    assign w_raw = {Btn_Ld, Btn_Dn, Btn_Up};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_deb;
        logic               r_deb_prev;
        logic [c_CNT_W-1:0] r_cnt;

        // Two-flop synchronizer, then a level debouncer: the accepted level
        // flips only after DB_CYCLES consecutive disagreeing samples.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                r_sync1    <= 1'b0;
                r_sync2    <= 1'b0;
                r_deb      <= 1'b0;
                r_deb_prev <= 1'b0;
                r_cnt      <= '0;
            end else begin
                r_sync1    <= w_raw[gi];
                r_sync2    <= r_sync1;
                r_deb_prev <= r_deb;
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_deb[gi]   = r_deb;
        // A press is the debounced rising edge; releases are not events
        assign w_press[gi] = r_deb & ~r_deb_prev;
    end

    // Debounced level of whichever direction is currently being repeated
    assign w_held_lvl = r_dir_dn ? w_deb[c_BTN_DN] : w_deb[c_BTN_UP];

    // Command FSM: issues one pulse per press, then auto-repeats a held
    // direction. Limit flags only mask the output, never the FSM timing.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= c_IDLE;
            r_dir_dn <= 1'b0;
            r_timer  <= '0;
            r_in     <= 5'b00000;
            r_load   <= 1'b0;
            r_up     <= 1'b0;
            r_down   <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_up   <= 1'b0;
            r_down <= 1'b0;
            if (w_press[c_BTN_LD]) begin
                // Load wins over everything and cancels any repeat in flight
                r_load  <= 1'b1;
                r_in    <= IN_Sw;
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_press[c_BTN_DN]) begin
                            r_down   <= ~Low;
                            r_dir_dn <= 1'b1;
                            r_timer  <= '0;
                            r_state  <= c_HOLD_DLY;
                        end else if (w_press[c_BTN_UP]) begin
                            r_up     <= ~High;
                            r_dir_dn <= 1'b0;
                            r_timer  <= '0;
                            r_state  <= c_HOLD_DLY;
                        end
                    end
                    c_HOLD_DLY, c_REPEAT: begin
                        if (!w_held_lvl) begin
                            r_state <= c_IDLE;
                        end else if (r_timer == ((r_state == c_HOLD_DLY) ?
                                                 c_DLY_LAST : c_RATE_LAST)) begin
                            if (r_dir_dn) begin
                                r_down <= ~Low;
                            end else begin
                                r_up <= ~High;
                            end
                            r_timer <= '0;
                            r_state <= c_REPEAT;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign IN   = r_in;
    assign Load = r_load;
    assign Up   = r_up;
    assign Down = r_down;

endmodule
`default_nettype wire

// File: doc/up_dn_cmd_gen.md
UP_DN_CMD_GEN -- requirements
Module: up_dn_cmd_gen

Interface
REQ-001 Parameter: DB_CYCLES, 4, consecutive stable cycles required to accept a button level change.
REQ-002 Parameter: RPT_DELAY, 16, cycles from first pulse to first auto-repeat pulse.
REQ-003 Parameter: RPT_RATE, 4, cycles between successive auto-repeat pulses.
REQ-004 Port: CLK  in  1  single clock; all state on rising edge.
REQ-005 Port: RST  in  1  reset, asynchronous, active-low.
REQ-006 Port: Btn_Up  in  1  raw asynchronous up button, high = pressed.
REQ-007 Port: Btn_Dn  in  1  raw asynchronous down button, high = pressed.
REQ-008 Port: Btn_Ld  in  1  raw asynchronous load button, high = pressed.
REQ-009 Port: IN_Sw  in  5  load value switches, quasi-static.
REQ-010 Port: High  in  1  counter at maximum (5'b11111), from the downstream counter.
REQ-011 Port: Low  in  1  counter at minimum (5'b00000), from the downstream counter.
REQ-012 Port: IN  out  5  registered load value to the counter.
REQ-013 Port: Load, Up, Down  out  1 each  registered single-cycle command pulses to the counter.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each synchronized button SHALL have its own debounce counter; debounced level flips only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-016 A press event SHALL be a debounced 0->1 transition; releases generate no command.
REQ-017 Latency: raw level stable from before edge k SHALL produce the press pulse asserted after edge k+DB_CYCLES+2, high for exactly one cycle.
REQ-018 At most one of Load/Up/Down SHALL be high in any cycle; priority Load > Down > Up.
REQ-019 FSM states: IDLE, HOLD_DLY, REPEAT; reset state IDLE.
REQ-020 IDLE: Ld press -> Load pulse, stay IDLE; Dn press (else Up press) -> pulse, record held direction, clear repeat timer, go HOLD_DLY.
REQ-021 HOLD_DLY: held button debounced low -> IDLE; timer reaches RPT_DELAY -> pulse, clear timer, go REPEAT.
REQ-022 REPEAT: held button debounced low -> IDLE; timer reaches RPT_RATE -> pulse, clear timer.
REQ-023 Ld press in HOLD_DLY or REPEAT SHALL emit Load, abort repeat, go IDLE; held Up/Dn then needs a fresh press.
REQ-024 Other-direction press in HOLD_DLY/REPEAT SHALL be ignored.
REQ-025 Up SHALL be suppressed while High=1, Down while Low=1; FSM and timers advance as if issued.
REQ-026 IN SHALL load IN_Sw on the edge that asserts Load and hold otherwise.
REQ-027 Repeat timer SHALL be wide enough for max(RPT_DELAY,RPT_RATE) without wrap.

Reset
REQ-028 RST low SHALL immediately clear IN=5'b00000, Load=Up=Down=0, synchronizers, debounced levels, debounce counters, timers; FSM=IDLE.
REQ-029 Button held through reset release SHALL produce a press pulse per REQ-017, counted from the first edge after release.

Verification (DB_CYCLES=4, RPT_DELAY=16, RPT_RATE=4)
REQ-030 Btn_Up toggling every 2 cycles for 20 cycles, then low -> no Up pulse.
REQ-031 Btn_Up high from before edge k for 10 cycles, High=0 -> exactly one Up pulse, after edge k+6.
REQ-032 Btn_Dn high from before edge k, low from before edge k+40, Low=0 -> Down after edges k+6, k+22, k+26, k+30, k+34, k+38, k+42 (7 pulses), none later.
REQ-033 Btn_Up repeating, IN_Sw=5'b00011, Btn_Ld pressed -> one Load pulse, IN=5'b00011, no further Up while Btn_Up stays high.
REQ-034 Btn_Up and Btn_Dn rise same cycle, Low=0 -> Down pulses only; repeat with High=1, Btn_Up alone -> no Up pulse.
REQ-035 RST low during REPEAT -> all outputs 0 in same cycle, no pulse until fresh debounced press.
